instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch front end for the 16-bit multi-cycle processor. It drives the address of the synchronous instruction ROM, captures the returned words into a small prefetch queue, and presents them to the decode/control stage through a valid/ready handshake. Branch and jump targets from the datapath arrive as a redirect that flushes queued and in-flight fetches. The block replaces direct PC-to-ROM addressing in the processor top.

## Interface
- ADDR_W, 12, instruction address width (ROM word address)
- DATA_W, 16, instruction word width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)

- CLOCK_50  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- mem_addr  out  ADDR_W  ROM read address, sampled by ROM on the rising edge
- mem_q  in  DATA_W  ROM read data, valid the cycle after its address was sampled (fixed 1-cycle latency, no stall)
- redirect  in  1  load new fetch PC, flush queue and in-flight read
- redirect_pc  in  ADDR_W  new fetch PC, sampled when redirect=1
- instr  out  DATA_W  head-of-queue instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  head entry present
- instr_ready  in  1  consumer accepts head this cycle

## Operation
- State: fetch_pc (ADDR_W), in-flight flag plus its address, queue of DEPTH entries {word, pc}, rd/wr pointers, count (0..DEPTH).
- mem_addr = fetch_pc, combinational from the register.
- Issue condition: issue = !redirect && (count + inflight) < DEPTH, using current-cycle count (no credit for a same-cycle pop).
- On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 modulo 2^ADDR_W (0xFFF wraps to 0x000). Otherwise inflight<=0.
- Response: while inflight=1 and no redirect, {mem_q, inflight_pc} is written to the queue tail at the edge.
- Pop: instr_valid && instr_ready removes the head at the edge.
- Push and pop in the same cycle: count unchanged; push never overflows because of the issue credit rule.
- instr_valid = (count != 0); instr/instr_pc driven from head entry. No bypass: a word is visible only after it is written into the queue.
- Redirect (priority over everything except reset): at the edge, fetch_pc<=redirect_pc, count<=0, pointers<=0, inflight<=0 (response in the ROM pipe is discarded). A same-cycle handshake counts as accepted by the consumer; the entry is flushed regardless. No issue in the redirect cycle.
- Reset: fetch_pc=0, inflight=0, count=0, pointers=0 → mem_addr=0, instr_valid=0. instr/instr_pc are don't-care while instr_valid=0. Reset mid-operation discards any in-flight ROM data.
- While instr_valid=1 and instr_ready=0, instr and instr_pc hold stable.

## Timing
- Cycle 0 = first cycle with reset=0: issue addr 0. Cycle 1: mem_q=ROM[0], written at end of cycle 1. Cycle 2: instr_valid=1, instr_pc=0.
- Fetch-to-visible latency: 2 cycles. Redirect at cycle r → issue redirect_pc at r+1 → instr_valid with instr_pc=redirect_pc at r+3.
- Sustained throughput with instr_ready held 1: one instruction per cycle from cycle 2, steady-state count=1.
- Backpressure: with instr_ready=0, at most DEPTH entries accumulate; issue stops once count+inflight=DEPTH, mem_addr holds at next unfetched address. Resuming ready restores 1/cycle with no bubble while count ≥2.

## Test plan
- Reset then instr_ready=1, ROM[i]=0xA000+i: instr_valid rises cycle 2; instr_pc 0,1,2,… one per cycle, instr=0xA000+pc, no gaps or duplicates.
- instr_ready=0 for 10 cycles after reset: count reaches 4 (pcs 0–3), mem_addr frozen at 4, instr stays 0xA000; raise ready: pcs 0–6 delivered consecutively.
- Redirect to 0x123 at cycle 6 with queue non-empty: instr_valid=0 cycles 7–8, instr_pc=0x123 at cycle 9, no pre-redirect pc after cycle 6.
- Redirect with simultaneous handshake and an in-flight read: head counted accepted once, in-flight word never appears, next pc is redirect_pc.
- Redirect to 0xFFE, ready=1: pcs 0xFFE, 0xFFF, 0x000, 0x001 in order.
- reset=1 for one cycle mid-stream with queue full: next cycle instr_valid=0, mem_addr=0; delivery restarts at pc 0 two cycles after reset drops.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: drives the synchronous ROM address, buffers returned
// words in a small prefetch queue and hands them to decode over a valid/ready handshake.
module instr_fetch_queue #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetchPc;
  logic              inflight;
  logic [ADDR_W-1:0] inflightPc;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] qWord [DEPTH];
  logic [ADDR_W-1:0] qPc   [DEPTH];

  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              push;
  logic              pop;

  always_comb begin
    // Outstanding read reserves a slot, so the queue can never overflow on its return.
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    issue     = !redirect && (occupancy < (CNT_W+1)'(DEPTH));
    push      = inflight && !redirect;
    pop       = instr_valid && instr_ready;
  end

  assign mem_addr    = fetchPc;
  assign instr_valid = (count != '0);
  assign instr       = qWord[rdPtr];
  assign instr_pc    = qPc[rdPtr];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fetchPc    <= '0;
      inflight   <= 1'b0;
      inflightPc <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
    end else if (redirect) begin
      fetchPc  <= redirect_pc;
      inflight <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflightPc <= fetchPc;
        fetchPc    <= fetchPc + ADDR_W'(1);
      end
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      qWord[wrPtr] <= mem_q;
      qPc[wrPtr]   <= inflightPc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: ROM model returns 0xA000+addr one cycle after the
// address is sampled; expected values below are hand-derived per cycle.
module tb_instr_fetch_queue;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [11:0] mem_addr;
  logic [15:0] mem_q;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int nAsserts = 0;
  int nFails   = 0;

  instr_fetch_queue #(.ADDR_W(12), .DATA_W(16), .DEPTH(4)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_q      (mem_q),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) mem_q <= 16'hA000 + {4'h0, mem_addr};

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench in cycle 0 (first cycle with reset low).
  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    tick(); tick();

    // Streaming with ready held high
    instr_ready = 1'b1;
    doReset();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr",  32'(mem_addr),   32'h000);
    tick();
    check("c1_valid", 32'(instr_valid), 32'd0);
    check("c1_addr",  32'(mem_addr),   32'h001);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("str_valid", 32'(instr_valid), 32'd1);
      check("str_pc",    32'(instr_pc),    32'(k));
      check("str_instr", 32'(instr),       32'hA000 + 32'(k));
    end

    // Backpressure: ready low for cycles 0..9
    instr_ready = 1'b0;
    doReset();
    tick(); tick();
    for (int c = 2; c < 10; c++) begin
      check("bp_pc",    32'(instr_pc), 32'h000);
      check("bp_instr", 32'(instr),    32'hA000);
      if (c >= 4) check("bp_addr", 32'(mem_addr), 32'h004);
      if (c < 9) tick();
    end
    tick();
    instr_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check("bp_rel_valid", 32'(instr_valid), 32'd1);
      check("bp_rel_pc",    32'(instr_pc),    32'(k));
      tick();
    end

    // Redirect to 0x123 at cycle 6 with queue non-empty and a read in flight
    doReset();
    for (int c = 0; c < 6; c++) tick();
    check("rd1_pre_pc", 32'(instr_pc), 32'h004);
    redirect = 1'b1; redirect_pc = 12'h123;
    tick();
    redirect = 1'b0;
    check("rd1_c7_valid", 32'(instr_valid), 32'd0);
    check("rd1_c7_addr",  32'(mem_addr),    32'h123);
    tick();
    check("rd1_c8_valid", 32'(instr_valid), 32'd0);
    tick();
    check("rd1_c9_valid", 32'(instr_valid), 32'd1);
    check("rd1_c9_pc",    32'(instr_pc),    32'h123);
    check("rd1_c9_instr", 32'(instr),       32'hA123);
    tick();
    check("rd1_c10_pc", 32'(instr_pc), 32'h124);

    // Redirect with same-cycle handshake (head 0x124 accepted) and a read in flight
    redirect = 1'b1; redirect_pc = 12'h200;
    tick();
    redirect = 1'b0;
    check("rd2_valid0", 32'(instr_valid), 32'd0);
    check("rd2_addr",   32'(mem_addr),    32'h200);
    tick();
    check("rd2_valid1", 32'(instr_valid), 32'd0);
    tick();
    check("rd2_pc0",    32'(instr_pc), 32'h200);
    check("rd2_instr0", 32'(instr),    32'hA200);
    tick();
    check("rd2_pc1",    32'(instr_pc), 32'h201);

    // Redirect near the top of the address space: wrap 0xFFF -> 0x000
    redirect = 1'b1; redirect_pc = 12'hFFE;
    tick();
    redirect = 1'b0;
    check("wrap_addr0", 32'(mem_addr), 32'hFFE);
    tick();
    check("wrap_addr1", 32'(mem_addr), 32'hFFF);
    tick();
    check("wrap_addr2", 32'(mem_addr), 32'h000);
    check("wrap_pc0",   32'(instr_pc), 32'hFFE);
    tick();
    check("wrap_pc1",    32'(instr_pc), 32'hFFF);
    check("wrap_instr1", 32'(instr),    32'hAFFF);
    tick();
    check("wrap_pc2",    32'(instr_pc), 32'h000);
    check("wrap_instr2", 32'(instr),    32'hA000);
    tick();
    check("wrap_pc3",    32'(instr_pc), 32'h001);

    // Fill the queue (head 0x001 held), then reset mid-stream
    instr_ready = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_pc",    32'(instr_pc),    32'h001);
    check("full_instr", 32'(instr),       32'hA001);
    check("full_addr",  32'(mem_addr),    32'h005);
    instr_ready = 1'b1;
    doReset();
    check("mrst_valid", 32'(instr_valid), 32'd0);
    check("mrst_addr",  32'(mem_addr),    32'h000);
    tick();
    check("mrst_c1_valid", 32'(instr_valid), 32'd0);
    tick();
    check("mrst_c2_valid", 32'(instr_valid), 32'd1);
    check("mrst_c2_pc",    32'(instr_pc),    32'h000);
    check("mrst_c2_instr", 32'(instr),       32'hA000);
    tick();
    check("mrst_c3_pc", 32'(instr_pc), 32'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
